// File: rtl/elastic_fu.sv
// elastic_fu: executes one configured ALU op per accepted operand pair; result leaves via a 2-slot elastic buffer.
// Latency: 1 edge from accept to dout_v for all ops; MUL takes 2 edges when ELASTIC_FU_MUL_EN is defined.
// Backpressure: din_r is driven only by registered state (skid full, MUL pending), never combinationally by dout_r.
//
// Ports: clk/rst_n (async active-low reset); din_1/din_2/din_v/din_r operand-pair channel;
//        dout/dout_v/dout_r result channel; op_cfg operation select; feedback selects acc as operand B.
// Build option: define ELASTIC_FU_MUL_EN to build the registered multiplier and its MUL_WAIT state.
module elastic_fu #(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [DATA_WIDTH-1:0] din_1,
  input  logic [DATA_WIDTH-1:0] din_2,
  input  logic                  din_v,
  output logic                  din_r,
  output logic [DATA_WIDTH-1:0] dout,
  output logic                  dout_v,
  input  logic                  dout_r,
  input  logic [3:0]            op_cfg,
  input  logic                  feedback
);

  localparam int SHW = $clog2(DATA_WIDTH);

  logic [DATA_WIDTH-1:0] acc_q, acc_d;
  logic [DATA_WIDTH-1:0] main_dat_q, main_dat_d;
  logic                  main_vld_q, main_vld_d;
  logic [DATA_WIDTH-1:0] skid_dat_q, skid_dat_d;
  logic                  skid_vld_q, skid_vld_d;

  logic [DATA_WIDTH-1:0] opb;
  logic [DATA_WIDTH-1:0] alu_res;
  logic [SHW-1:0]        shamt;
  logic                  acc_hs;
  logic                  drain;
  logic                  wr_vld;
  logic [DATA_WIDTH-1:0] wr_dat;

  // In feedback mode the accumulator stands in for operand B; the registered
  // acc makes back-to-back feedback tokens see the previous result with no bubble.
  assign opb    = feedback ? acc_q : din_2;
  assign shamt  = opb[SHW-1:0];
  assign acc_hs = din_v && din_r;
  assign drain  = main_vld_q && dout_r;

  always_comb begin
    alu_res = '0;
    case (op_cfg)
      4'd0:  alu_res = din_1 + opb;
      4'd1:  alu_res = din_1 - opb;
`ifdef ELASTIC_FU_MUL_EN
      4'd2:  alu_res = din_1 * opb;
`endif
      4'd3:  alu_res = din_1 & opb;
      4'd4:  alu_res = din_1 | opb;
      4'd5:  alu_res = din_1 ^ opb;
      4'd6:  alu_res = din_1 << shamt;
      4'd7:  alu_res = din_1 >> shamt;
      4'd8:  alu_res = $signed(din_1) >>> shamt;
      4'd9:  alu_res = {{(DATA_WIDTH-1){1'b0}}, ($signed(din_1) < $signed(opb))};
      4'd10: alu_res = din_1;
      default: alu_res = '0;
    endcase
  end

`ifdef ELASTIC_FU_MUL_EN
  typedef enum logic {ST_IDLE, ST_MUL_WAIT} mul_st_e;

  mul_st_e               st_q;
  logic                  mul_busy_q;
  logic [DATA_WIDTH-1:0] mul_q;
  logic                  is_mul;

  assign is_mul = (op_cfg == 4'd2);

  // The product is registered on accept and written to the buffer on the next
  // edge. din_r was high at accept, so the skid slot is guaranteed free then.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st_q       <= ST_IDLE;
      mul_busy_q <= 1'b0;
      mul_q      <= '0;
    end else begin
      case (st_q)
        ST_IDLE: begin
          if (acc_hs && is_mul) begin
            st_q       <= ST_MUL_WAIT;
            mul_busy_q <= 1'b1;
            mul_q      <= alu_res;
          end
        end
        ST_MUL_WAIT: begin
          st_q       <= ST_IDLE;
          mul_busy_q <= 1'b0;
        end
      endcase
    end
  end

  assign din_r  = rst_n && !skid_vld_q && !mul_busy_q;
  assign wr_vld = (acc_hs && !is_mul) || mul_busy_q;
  assign wr_dat = mul_busy_q ? mul_q : alu_res;
`else
  assign din_r  = rst_n && !skid_vld_q;
  assign wr_vld = acc_hs;
  assign wr_dat = alu_res;
`endif

  // Main slot drives the output; skid only fills when main is held this cycle.
  always_comb begin
    main_vld_d = main_vld_q;
    main_dat_d = main_dat_q;
    skid_vld_d = skid_vld_q;
    skid_dat_d = skid_dat_q;
    if (drain) begin
      if (skid_vld_q) begin
        main_vld_d = 1'b1;
        main_dat_d = skid_dat_q;
        skid_vld_d = wr_vld;
        if (wr_vld) skid_dat_d = wr_dat;
      end else begin
        main_vld_d = wr_vld;
        if (wr_vld) main_dat_d = wr_dat;
      end
    end else if (wr_vld) begin
      if (!main_vld_q) begin
        main_vld_d = 1'b1;
        main_dat_d = wr_dat;
      end else begin
        skid_vld_d = 1'b1;
        skid_dat_d = wr_dat;
      end
    end
  end

  assign acc_d = wr_vld ? wr_dat : acc_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q      <= '0;
      main_vld_q <= 1'b0;
      main_dat_q <= '0;
      skid_vld_q <= 1'b0;
      skid_dat_q <= '0;
    end else begin
      acc_q      <= acc_d;
      main_vld_q <= main_vld_d;
      main_dat_q <= main_dat_d;
      skid_vld_q <= skid_vld_d;
      skid_dat_q <= skid_dat_d;
    end
  end

  assign dout   = main_dat_q;
  assign dout_v = main_vld_q;

endmodule

// File: tb/tb_elastic_fu.sv
// tb_elastic_fu: directed vectors with hand-computed results for elastic_fu (DATA_WIDTH=32).
// Latency: inputs change and outputs are sampled 1 time unit after each rising edge.
// Backpressure: exercised by holding dout_r low against a 3-token burst.
module tb_elastic_fu;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] din_1 = '0;
  logic [31:0] din_2 = '0;
  logic        din_v = 1'b0;
  logic        din_r;
  logic [31:0] dout;
  logic        dout_v;
  logic        dout_r = 1'b1;
  logic [3:0]  op_cfg = 4'd0;
  logic        feedback = 1'b0;

  int n_vec = 0;
  int n_err = 0;

  elastic_fu #(.DATA_WIDTH(32)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .din_1    (din_1),
    .din_2    (din_2),
    .din_v    (din_v),
    .din_r    (din_r),
    .dout     (dout),
    .dout_v   (dout_v),
    .dout_r   (dout_r),
    .op_cfg   (op_cfg),
    .feedback (feedback)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Single token, result expected one edge later in the main slot.
  task automatic one(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                     input logic [31:0] exp, input string tag);
    op_cfg = op;
    din_1  = a;
    din_2  = b;
    din_v  = 1'b1;
    tick;
    din_v  = 1'b0;
    chk({tag, "_v"}, {31'd0, dout_v}, 32'd1);
    chk(tag, dout, exp);
  endtask

  task automatic do_reset;
    din_v = 1'b0;
    rst_n = 1'b0;
    tick;
    tick;
    rst_n = 1'b1;
    #1;
  endtask

  initial begin
    // Reset values
    tick;
    tick;
    chk("rst_dout_v", {31'd0, dout_v}, 32'd0);
    chk("rst_dout", dout, 32'd0);
    chk("rst_din_r", {31'd0, din_r}, 32'd0);
    rst_n = 1'b1;
    #1;
    chk("rel_din_r", {31'd0, din_r}, 32'd1);

    // ADD stream at full throughput: 3i each cycle, latency 1
    op_cfg = 4'd0;
    for (int i = 1; i <= 8; i++) begin
      din_1 = i;
      din_2 = 2 * i;
      din_v = 1'b1;
      chk($sformatf("add_rdy%0d", i), {31'd0, din_r}, 32'd1);
      tick;
      chk($sformatf("add_v%0d", i), {31'd0, dout_v}, 32'd1);
      chk($sformatf("add%0d", i), dout, 3 * i);
    end
    din_v = 1'b0;
    tick;
    chk("add_drained", {31'd0, dout_v}, 32'd0);

    // Individual operations
    one(4'd1, 32'd5, 32'd7, 32'hFFFF_FFFE, "sub");
    one(4'd8, 32'h8000_0000, 32'd35, 32'hF000_0000, "sra");
    one(4'd9, 32'hFFFF_FFFF, 32'd0, 32'd1, "slt_neg");
    one(4'd9, 32'd7, 32'd5, 32'd0, "slt_pos");
    one(4'd3, 32'hF0F0_1234, 32'h0FF0_0004, 32'h00F0_0004, "and");
    one(4'd4, 32'hF0F0_1234, 32'h0FF0_0004, 32'hFFF0_1234, "or");
    one(4'd5, 32'hF0F0_1234, 32'h0FF0_0004, 32'hFF00_1230, "xor");
    one(4'd6, 32'hF0F0_1234, 32'h0FF0_0004, 32'h0F01_2340, "sll");
    one(4'd7, 32'hF0F0_1234, 32'h0FF0_0004, 32'h0F0F_0123, "srl");
    one(4'd10, 32'hF0F0_1234, 32'h0FF0_0004, 32'hF0F0_1234, "pass");
    one(4'd12, 32'hF0F0_1234, 32'h0FF0_0004, 32'd0, "op12");
    tick;

    // Multiply
`ifdef ELASTIC_FU_MUL_EN
    op_cfg = 4'd2;
    din_1 = 32'd3;
    din_2 = 32'd4;
    din_v = 1'b1;
    tick;
    chk("mul1_busy_rdy", {31'd0, din_r}, 32'd0);
    chk("mul1_wait_v", {31'd0, dout_v}, 32'd0);
    din_1 = 32'h0001_0000;
    din_2 = 32'h0001_0000;
    tick;
    chk("mul1_v", {31'd0, dout_v}, 32'd1);
    chk("mul1", dout, 32'd12);
    chk("mul1_rdy_back", {31'd0, din_r}, 32'd1);
    tick;
    chk("mul2_busy_rdy", {31'd0, din_r}, 32'd0);
    chk("mul2_wait_v", {31'd0, dout_v}, 32'd0);
    din_v = 1'b0;
    tick;
    chk("mul2_v", {31'd0, dout_v}, 32'd1);
    chk("mul2", dout, 32'd0);
`else
    one(4'd2, 32'd3, 32'd4, 32'd0, "mul1_off");
    one(4'd2, 32'h0001_0000, 32'h0001_0000, 32'd0, "mul2_off");
`endif
    tick;

    // Back-pressure: two accepted, third held until main drains
    op_cfg = 4'd0;
    dout_r = 1'b0;
    din_2  = 32'd0;
    din_1  = 32'd10;
    din_v  = 1'b1;
    chk("bp_rdy1", {31'd0, din_r}, 32'd1);
    tick;
    din_1 = 32'd20;
    chk("bp_rdy2", {31'd0, din_r}, 32'd1);
    tick;
    din_1 = 32'd30;
    chk("bp_full_rdy", {31'd0, din_r}, 32'd0);
    tick;
    chk("bp_hold_rdy", {31'd0, din_r}, 32'd0);
    chk("bp_hold_dat", dout, 32'd10);
    dout_r = 1'b1;
    tick;
    chk("bp_out20_v", {31'd0, dout_v}, 32'd1);
    chk("bp_out20", dout, 32'd20);
    chk("bp_rdy_back", {31'd0, din_r}, 32'd1);
    tick;
    din_v = 1'b0;
    chk("bp_out30_v", {31'd0, dout_v}, 32'd1);
    chk("bp_out30", dout, 32'd30);
    tick;
    chk("bp_empty", {31'd0, dout_v}, 32'd0);

    // Feedback accumulate from a fresh acc; din_2 is noise
    do_reset;
    feedback = 1'b1;
    op_cfg   = 4'd0;
    din_1    = 32'd1;
    for (int k = 1; k <= 5; k++) begin
      din_2 = $urandom;
      din_v = 1'b1;
      tick;
      chk($sformatf("fb%0d", k), dout, k);
    end
    din_v    = 1'b0;
    feedback = 1'b0;
    tick;

    // Reset with both slots occupied
    dout_r = 1'b0;
    din_1  = 32'd7;
    din_v  = 1'b1;
    tick;
    din_1 = 32'd8;
    tick;
    din_v = 1'b0;
    chk("mid_full_v", {31'd0, dout_v}, 32'd1);
    chk("mid_full_rdy", {31'd0, din_r}, 32'd0);
    #2;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_v", {31'd0, dout_v}, 32'd0);
    chk("mid_rst_rdy", {31'd0, din_r}, 32'd0);
    chk("mid_rst_dout", dout, 32'd0);
    tick;
    tick;
    rst_n  = 1'b1;
    dout_r = 1'b1;
    #1;
    one(4'd0, 32'd1, 32'd1, 32'd2, "post_rst_add");
    feedback = 1'b1;
    one(4'd0, 32'd5, 32'hDEAD_BEEF, 32'd7, "post_rst_acc");
    feedback = 1'b0;
    tick;
    chk("final_empty", {31'd0, dout_v}, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
